// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control bundle and the pipeline sequencer FSM.
// Bundle layout MSB..LSB: is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write, alu_src, write_enable, pc_to_reg, is_ecall.
package ctrl_pkg;

    localparam int CTRL_W = 10;

    localparam int CTRL_IS_JAL       = 9;
    localparam int CTRL_IS_JALR      = 8;
    localparam int CTRL_BRANCH       = 7;
    localparam int CTRL_MEM_READ     = 6;
    localparam int CTRL_MEM_TO_REG   = 5;
    localparam int CTRL_MEM_WRITE    = 4;
    localparam int CTRL_ALU_SRC      = 3;
    localparam int CTRL_WRITE_ENABLE = 2;
    localparam int CTRL_PC_TO_REG    = 1;
    localparam int CTRL_IS_ECALL     = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // A stage slot is a bubble unless valid; ctrl never carries stale enables.
    function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline slot: valid flag plus control bundle, loading the incoming slot or a bubble.
module ctrl_stage_reg
#(
    parameter int W = ctrl_pkg::CTRL_W
)
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] ctrl_i,
    output logic         valid_o,
    output logic [W-1:0] ctrl_o
);

    logic         valid_d, valid_q;
    logic [W-1:0] ctrl_d, ctrl_q;

    // An invalid incoming slot is stored as an all-zero bubble.
    always_comb begin
        valid_d = load_i & valid_i;
        ctrl_d  = valid_d ? ctrl_i : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/ctrl_pipe_sequencer.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with stall bubbles, flush squash and ECALL halt drain.
// Optional statistics counters are built when CTRL_STATS_EN is defined.
//
// state    | meaning
// ST_RUN   | normal issue; stall/flush honoured; halting ECALL moves to DRAIN
// ST_DRAIN | front end frozen, bubbles into ID/EX until the ECALL retires from WB
// ST_HALTED| sticky halt; pipeline holds bubbles until reset
module ctrl_pipe_sequencer
#(
    parameter int CTRL_W = ctrl_pkg::CTRL_W,
    parameter int STAT_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_halt_cond,
    input  logic              stall_req,
    input  logic              flush_req,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              mem_valid,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic              is_halted
`ifdef CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_bubbles,
    output logic [STAT_W-1:0] stat_flushes,
    output logic [STAT_W-1:0] stat_cycles
`endif
);

    import ctrl_pkg::*;

    logic [1:0] state_d, state_q;
    logic       in_run;
    logic       flush_act;
    logic       stall_act;
    logic       ex_load;
    logic       halt_entry;
    logic       ecall_retiring;

    assign in_run    = (state_q == ST_RUN);
    assign flush_act = in_run & flush_req;
    assign stall_act = in_run & stall_req & ~flush_req;
    assign ex_load   = in_run & ~flush_req & ~stall_req;

    // Only an ECALL that actually enters ID/EX can start the drain.
    assign halt_entry     = ex_load & id_valid & id_ctrl[CTRL_IS_ECALL] & id_halt_cond;
    assign ecall_retiring = wb_valid & wb_ctrl[CTRL_IS_ECALL];

    assign pc_write    = in_run & ~stall_act;
    assign if_id_write = in_run & ~stall_act;
    assign if_id_flush = flush_act;
    assign is_halted   = (state_q == ST_HALTED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_entry)     state_d = ST_DRAIN;
            ST_DRAIN:  if (ecall_retiring) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    ctrl_stage_reg #(.W(CTRL_W)) u_id_ex (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (ex_load),
        .valid_i (id_valid),
        .ctrl_i  (id_ctrl),
        .valid_o (ex_valid),
        .ctrl_o  (ex_ctrl)
    );

    ctrl_stage_reg #(.W(CTRL_W)) u_ex_mem (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (1'b1),
        .valid_i (ex_valid),
        .ctrl_i  (ex_ctrl),
        .valid_o (mem_valid),
        .ctrl_o  (mem_ctrl)
    );

    ctrl_stage_reg #(.W(CTRL_W)) u_mem_wb (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (1'b1),
        .valid_i (mem_valid),
        .ctrl_i  (mem_ctrl),
        .valid_o (wb_valid),
        .ctrl_o  (wb_ctrl)
    );

`ifdef CTRL_STATS_EN
    logic [STAT_W-1:0] bubbles_d, bubbles_q;
    logic [STAT_W-1:0] flushes_d, flushes_q;
    logic [STAT_W-1:0] cycles_d, cycles_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Counters freeze once halted so they describe the run that just ended.
    always_comb begin
        bubbles_d = bubbles_q;
        flushes_d = flushes_q;
        cycles_d  = cycles_q;
        if (!is_halted) begin
            cycles_d = sat_inc(cycles_q);
            if (stall_act) bubbles_d = sat_inc(bubbles_q);
            if (flush_act) flushes_d = sat_inc(flushes_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubbles_q <= '0;
            flushes_q <= '0;
            cycles_q  <= '0;
        end else begin
            bubbles_q <= bubbles_d;
            flushes_q <= flushes_d;
            cycles_q  <= cycles_d;
        end
    end

    assign stat_bubbles = bubbles_q;
    assign stat_flushes = flushes_q;
    assign stat_cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// Directed bench for ctrl_pipe_sequencer: scoreboard of expected ID/EX entries shifted through EX/MEM and MEM/WB.
module tb_ctrl_pipe_sequencer;

    localparam logic [9:0] C_ADD   = 10'h004;
    localparam logic [9:0] C_ADDI  = 10'h00C;
    localparam logic [9:0] C_LOAD  = 10'h06C;
    localparam logic [9:0] C_SW    = 10'h018;
    localparam logic [9:0] C_BEQ   = 10'h080;
    localparam logic [9:0] C_JAL   = 10'h206;
    localparam logic [9:0] C_ECALL = 10'h001;

    localparam logic [1:0] M_RUN   = 2'd0;
    localparam logic [1:0] M_DRAIN = 2'd1;
    localparam logic [1:0] M_HALT  = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_ctrl;
    logic       id_halt_cond;
    logic       stall_req;
    logic       flush_req;
    logic       pc_write, if_id_write, if_id_flush;
    logic       ex_valid, mem_valid, wb_valid;
    logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic       is_halted;
`ifdef CTRL_STATS_EN
    logic [31:0] stat_bubbles, stat_flushes, stat_cycles;
    int unsigned m_bub, m_fl, m_cyc;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;
    logic [10:0] sb[$];
    logic [1:0]  m_state;

    always #5 clk = ~clk;

    ctrl_pipe_sequencer #(.CTRL_W(10), .STAT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_halt_cond (id_halt_cond),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .mem_valid    (mem_valid),
        .mem_ctrl     (mem_ctrl),
        .wb_valid     (wb_valid),
        .wb_ctrl      (wb_ctrl),
        .is_halted    (is_halted)
`ifdef CTRL_STATS_EN
        ,
        .stat_bubbles (stat_bubbles),
        .stat_flushes (stat_flushes),
        .stat_cycles  (stat_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset();
        sb.delete();
        repeat (3) sb.push_back(11'h0);
        m_state = M_RUN;
`ifdef CTRL_STATS_EN
        m_bub = 0; m_fl = 0; m_cyc = 0;
`endif
    endtask

    task automatic check_stages();
        chk($sformatf("ex@%0d", n),  {21'h0, ex_valid,  ex_ctrl},  {21'h0, sb[$]});
        chk($sformatf("mem@%0d", n), {21'h0, mem_valid, mem_ctrl}, {21'h0, sb[$-1]});
        chk($sformatf("wb@%0d", n),  {21'h0, wb_valid,  wb_ctrl},  {21'h0, sb[$-2]});
        chk($sformatf("halted@%0d", n), is_halted, m_state == M_HALT);
`ifdef CTRL_STATS_EN
        chk($sformatf("st_bub@%0d", n), stat_bubbles, m_bub);
        chk($sformatf("st_fl@%0d", n),  stat_flushes, m_fl);
        chk($sformatf("st_cyc@%0d", n), stat_cycles,  m_cyc);
`endif
    endtask

    // Drive one ID-stage cycle, check the combinational enables, then the registered stages after the edge.
    task automatic step(input logic v, input logic [9:0] c, input logic hc, input logic st, input logic fl);
        logic [10:0] entry;
        logic [10:0] wb_now;
        logic [1:0]  nxt;
        logic        run;
        id_valid = v; id_ctrl = c; id_halt_cond = hc; stall_req = st; flush_req = fl;
        #1;
        n++;
        run = (m_state == M_RUN);
        chk($sformatf("pc_write@%0d", n),    pc_write,    run && !(st && !fl));
        chk($sformatf("if_id_write@%0d", n), if_id_write, run && !(st && !fl));
        chk($sformatf("if_id_flush@%0d", n), if_id_flush, run && fl);
        entry  = (run && !fl && !st && v) ? {1'b1, c} : 11'h0;
        wb_now = sb[$-2];
        nxt    = m_state;
        if (run && entry[10] && entry[0] && hc) nxt = M_DRAIN;
        else if (m_state == M_DRAIN && wb_now[10] && wb_now[0]) nxt = M_HALT;
`ifdef CTRL_STATS_EN
        if (m_state != M_HALT) begin
            m_cyc++;
            if (run && st && !fl) m_bub++;
            if (run && fl) m_fl++;
        end
`endif
        sb.push_back(entry);
        @(posedge clk);
        #1;
        m_state = nxt;
        if (sb.size() > 3) void'(sb.pop_front());
        check_stages();
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_ctrl = '0; id_halt_cond = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
        sb_reset();
        #6;
        check_stages();
        chk("rst_pc_write", pc_write, 1'b1);
        chk("rst_if_id_write", if_id_write, 1'b1);
        chk("rst_if_id_flush", if_id_flush, 1'b0);
        #1 reset = 1'b0;

        // Hazard-free stream, including an invalid slot carrying junk ctrl.
        step(1, C_ADD,  0, 0, 0);
        step(1, C_ADDI, 0, 0, 0);
        step(1, C_SW,   0, 0, 0);
        step(0, C_JAL,  0, 0, 0);
        step(1, C_BEQ,  0, 0, 0);
        step(1, C_JAL,  0, 0, 0);

        // Load-use: one stall cycle, then the ADD re-presented.
        step(1, C_LOAD, 0, 0, 0);
        step(1, C_ADD,  0, 1, 0);
        step(1, C_ADD,  0, 0, 0);

        // Stall and flush together: flush wins.
        step(1, C_ADDI, 0, 1, 1);
        step(1, C_SW,   0, 0, 0);

        // Halting ECALL squashed by a flush.
        step(1, C_ECALL, 1, 0, 1);
        step(1, C_ADD,   0, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        chk("flushed_ecall_no_halt", is_halted, 1'b0);

        // ECALL without halt condition is an ordinary instruction.
        step(1, C_ECALL, 0, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        chk("plain_ecall_no_halt", is_halted, 1'b0);

        // Halting ECALL: drain ignores stall/flush, halt exactly 3 edges after the ID/EX load.
        step(1, C_ECALL, 1, 0, 0);
        chk("ecall_in_ex", {31'h0, ex_valid}, 32'h1);
        step(1, C_ADD, 0, 1, 1);
        chk("drain_edge1", is_halted, 1'b0);
        step(1, C_ADD, 0, 0, 1);
        chk("drain_edge2", is_halted, 1'b0);
        step(1, C_ADD, 0, 1, 0);
        chk("halt_edge3", is_halted, 1'b1);
        step(1, C_ADD, 0, 0, 0);
        step(1, C_LOAD, 0, 1, 1);
        chk("halt_sticky", is_halted, 1'b1);

        // Fresh start, then reset in the middle of a drain.
        reset = 1'b1;
        #2;
        sb_reset();
        reset = 1'b0;
        step(1, C_ADD,   0, 0, 0);
        step(1, C_ECALL, 1, 0, 0);
        step(1, C_ADD,   0, 0, 0);
        id_valid = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        sb_reset();
        check_stages();
        chk("midrst_mem_valid", mem_valid, 1'b0);
        chk("midrst_pc_write", pc_write, 1'b1);
        #1 reset = 1'b0;
        step(1, C_ADD,  0, 0, 0);
        step(1, C_ADDI, 0, 0, 0);
        step(1, C_ADD,  0, 0, 0);
        step(1, C_ADD,  0, 0, 0);
        chk("after_midrst_no_halt", is_halted, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
